// File: rtl/dma_pkg.sv
// Shared AXI constants, FSM state encoding and beat-size helper for the write-back DMA engine.
package dma_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // AXI AxSIZE encoding for a given data bus width in bits.
    function automatic int beat_size(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or after the pointer,
// returning both a one-hot grant and the binary index.
module rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_gnt,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    int w_c;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_c   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_c = int'(i_ptr) + i;
            if (w_c >= NUM_CH) w_c = w_c - NUM_CH;
            if (!o_any && i_req[w_c]) begin
                o_any      = 1'b1;
                o_gnt[w_c] = 1'b1;
                o_idx      = IDX_W'(w_c);
            end
        end
    end

endmodule

// File: rtl/dma_axi_wb_writer.sv
// Multi-channel cache write-back DMA: round-robin request arbitration, one AXI4 INCR burst per grant.
// Optional 4 KB crossing reject enabled by defining DMA_WB_BOUNDARY_CHECK_EN.
module dma_axi_wb_writer
    import dma_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    localparam int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         cpu_clk,
    input  logic                         cpu_rst_n,
    input  logic [NUM_CH-1:0]            wb_req,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] wb_addr,
    input  logic [NUM_CH*LEN_WIDTH-1:0]  wb_len,
    output logic [NUM_CH-1:0]            wb_done,
    output logic [NUM_CH-1:0]            wb_err,
    input  logic [DATA_WIDTH-1:0]        wb_data,
    input  logic                         wb_data_valid,
    output logic                         wb_data_ready,
    output logic [IDX_W-1:0]             wb_data_ch,
    output logic [ADDR_WIDTH-1:0]        m_awaddr,
    output logic [7:0]                   m_awlen,
    output logic [2:0]                   m_awsize,
    output logic [1:0]                   m_awburst,
    output logic                         m_awvalid,
    input  logic                         m_awready,
    output logic [DATA_WIDTH-1:0]        m_wdata,
    output logic [DATA_WIDTH/8-1:0]      m_wstrb,
    output logic                         m_wlast,
    output logic                         m_wvalid,
    input  logic                         m_wready,
    input  logic [1:0]                   m_bresp,
    input  logic                         m_bvalid,
    output logic                         m_bready,
    output logic [2:0]                   dbg_state
);

    // Handshake rule on every channel: a transfer happens on a clock edge where
    // valid and ready are both high; a source holds valid and payload until then.

    localparam int SIZE = beat_size(DATA_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~((ADDR_WIDTH'(1) << SIZE) - 1'b1);

    state_t                  r_state, w_next;
    logic [IDX_W-1:0]        r_ptr, r_ch;
    logic [NUM_CH-1:0]       r_gnt;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [LEN_WIDTH-1:0]    r_len, r_cnt;
    logic                    r_err;

    logic [NUM_CH-1:0]       w_gnt;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_any;
    logic [ADDR_WIDTH-1:0]   w_gnt_addr, w_aligned;
    logic [LEN_WIDTH-1:0]    w_gnt_len;
    logic                    w_beat, w_last, w_reject;

    rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
        .i_req (wb_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_gnt_addr = wb_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_gnt_len  = wb_len[w_idx*LEN_WIDTH +: LEN_WIDTH];
    assign w_aligned  = w_gnt_addr & ALIGN_MASK;
    assign w_beat     = (r_state == ST_W) && wb_data_valid && m_wready;
    assign w_last     = (r_cnt == r_len);

`ifdef DMA_WB_BOUNDARY_CHECK_EN
    logic [ADDR_WIDTH-1:0] w_bytes, w_end;
    assign w_bytes  = (ADDR_WIDTH'(w_gnt_len) + 1'b1) << SIZE;
    assign w_end    = w_aligned + w_bytes - 1'b1;
    assign w_reject = (w_end[ADDR_WIDTH-1:12] != w_aligned[ADDR_WIDTH-1:12]);
`else
    assign w_reject = 1'b0;
`endif

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) r_state <= ST_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        m_awvalid     = 1'b0;
        m_wvalid      = 1'b0;
        m_wlast       = 1'b0;
        wb_data_ready = 1'b0;
        m_bready      = 1'b0;
        wb_done       = '0;
        wb_err        = '0;
        case (r_state)
            ST_IDLE: if (w_any) w_next = w_reject ? ST_DONE : ST_AW;
            ST_AW: begin
                m_awvalid = 1'b1;
                if (m_awready) w_next = ST_W;
            end
            ST_W: begin
                m_wvalid      = wb_data_valid;
                wb_data_ready = m_wready;
                m_wlast       = w_last;
                if (w_beat && w_last) w_next = ST_B;
            end
            ST_B: begin
                m_bready = 1'b1;
                if (m_bvalid) w_next = ST_DONE;
            end
            ST_DONE: begin
                wb_done = r_gnt;
                wb_err  = r_err ? r_gnt : '0;
                w_next  = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_ptr  <= '0;
            r_ch   <= '0;
            r_gnt  <= '0;
            r_addr <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_any) begin
                r_addr <= w_aligned;
                r_len  <= w_gnt_len;
                r_ch   <= w_idx;
                r_gnt  <= w_gnt;
                r_err  <= w_reject;
                r_cnt  <= '0;
                if (int'(w_idx) == NUM_CH - 1) r_ptr <= '0;
                else                           r_ptr <= w_idx + 1'b1;
            end
            if (w_beat) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY are success.
            if (r_state == ST_B && m_bvalid)
                r_err <= (m_bresp == AXI_RESP_SLVERR) || (m_bresp == AXI_RESP_DECERR);
        end
    end

    assign m_awaddr   = r_addr;
    assign m_awlen    = 8'(r_len);
    assign m_awsize   = 3'(SIZE);
    assign m_awburst  = AXI_BURST_INCR;
    assign m_wdata    = wb_data;
    assign m_wstrb    = '1;
    assign wb_data_ch = r_ch;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_dma_axi_wb_writer.sv
// Bench for dma_axi_wb_writer: table of single-channel bursts plus hand sequences
// for arbitration order, reset mid-burst and the 4 KB boundary guard.
module tb_dma_axi_wb_writer;

    localparam int NUM_CH = 2;
    localparam int AW_W   = 32;
    localparam int DW     = 32;
    localparam int LW     = 8;

    logic                   cpu_clk = 1'b0;
    logic                   cpu_rst_n;
    logic [NUM_CH-1:0]      wb_req;
    logic [NUM_CH*AW_W-1:0] wb_addr;
    logic [NUM_CH*LW-1:0]   wb_len;
    logic [NUM_CH-1:0]      wb_done, wb_err;
    logic [DW-1:0]          wb_data;
    logic                   wb_data_valid, wb_data_ready;
    logic [0:0]             wb_data_ch;
    logic [AW_W-1:0]        m_awaddr;
    logic [7:0]             m_awlen;
    logic [2:0]             m_awsize;
    logic [1:0]             m_awburst;
    logic                   m_awvalid, m_awready;
    logic [DW-1:0]          m_wdata;
    logic [DW/8-1:0]        m_wstrb;
    logic                   m_wlast, m_wvalid, m_wready;
    logic [1:0]             m_bresp;
    logic                   m_bvalid, m_bready;
    logic [2:0]             dbg_state;

    int n_vec = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_q[$];

    always #5 cpu_clk = ~cpu_clk;

    dma_axi_wb_writer #(
        .NUM_CH(NUM_CH), .ADDR_WIDTH(AW_W), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
    ) dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_len(wb_len),
        .wb_done(wb_done), .wb_err(wb_err),
        .wb_data(wb_data), .wb_data_valid(wb_data_valid), .wb_data_ready(wb_data_ready),
        .wb_data_ch(wb_data_ch),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .dbg_state(dbg_state)
    );

    typedef struct {
        int          ch;
        logic [31:0] addr;
        int          len;
        logic [1:0]  bresp;
        int          aw_delay;
        int          period;
        bit          toggle;
        logic [31:0] exp_awaddr;
        bit          exp_err;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic post_req(input int ch, input logic [31:0] addr, input int len);
        wb_addr[ch*AW_W +: AW_W] = addr;
        wb_len[ch*LW +: LW]      = LW'(len);
        wb_req[ch]               = 1'b1;
    endtask

    // Serves one burst as AXI slave and data source; abort_at > 0 returns after that many beats.
    task automatic serve(input int ch, input int len, input logic [1:0] bresp,
                         input int aw_delay, input int period, input bit toggle,
                         input logic [31:0] exp_awaddr, input bit exp_err, input int abort_at);
        int n;
        int beats;
        int ph;
        bit presented;
        logic [DW-1:0] d;
        logic [DW-1:0] e;
        n = 0;
        while (!m_awvalid && n < 100) begin @(negedge cpu_clk); n++; end
        chk("aw_timeout", 64'(n >= 100), 0);
        chk("grant_ch", 64'(wb_data_ch), 64'(ch));
        chk("awaddr", 64'(m_awaddr), 64'(exp_awaddr));
        chk("awlen", 64'(m_awlen), 64'(len));
        chk("awsize", 64'(m_awsize), 64'd2);
        chk("awburst", 64'(m_awburst), 64'd1);
        repeat (aw_delay) @(negedge cpu_clk);
        chk("aw_hold", {31'd0, m_awvalid, m_awaddr}, {31'd0, 1'b1, exp_awaddr});
        m_awready = 1'b1;
        @(negedge cpu_clk);
        m_awready = 1'b0;
        beats = 0; ph = 0; n = 0; presented = 1'b0;
        while (beats < len + 1 && n < 3000) begin
            if (!presented) begin
                wb_data_valid = 1'b0;
                if (!toggle || $urandom_range(0, 1) == 1) begin
                    d = $urandom;
                    exp_q.push_back(d);
                    wb_data       = d;
                    wb_data_valid = 1'b1;
                    presented     = 1'b1;
                end
            end
            m_wready = ((ph % period) == 0);
            ph++;
            #1;
            chk("wready_pass", 64'(wb_data_ready), 64'(m_wready));
            if (m_wvalid && m_wready) begin
                e = exp_q.pop_front();
                chk("wdata", 64'(m_wdata), 64'(e));
                chk("wlast", 64'(m_wlast), 64'(beats == len));
                beats++;
                presented = 1'b0;
                if (abort_at > 0 && beats == abort_at) return;
            end
            @(negedge cpu_clk);
            n++;
        end
        wb_data_valid = 1'b0;
        m_wready      = 1'b0;
        chk("beat_count", 64'(beats), 64'(len + 1));
        n = 0;
        while (!m_bready && n < 50) begin @(negedge cpu_clk); n++; end
        chk("b_timeout", 64'(n >= 50), 0);
        chk("wvalid_after_last", 64'(m_wvalid), 0);
        repeat ($urandom_range(0, 2)) @(negedge cpu_clk);
        m_bresp  = bresp;
        m_bvalid = 1'b1;
        @(negedge cpu_clk);
        m_bvalid = 1'b0;
        n = 0;
        while (wb_done == '0 && n < 50) begin @(negedge cpu_clk); n++; end
        chk("done_vec", 64'(wb_done), 64'(1 << ch));
        chk("err_vec", 64'(wb_err), exp_err ? 64'(1 << ch) : 64'd0);
        wb_req[ch] = 1'b0;
        @(negedge cpu_clk);
        chk("done_pulse", 64'(wb_done), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 32'h0000_0020, 22,  2'b00, 3, 1, 1'b0, 32'h0000_0020, 1'b0};
        tbl[1] = '{1, 32'h0000_1000, 0,   2'b00, 0, 3, 1'b1, 32'h0000_1000, 1'b0};
        tbl[2] = '{1, 32'h0000_0040, 3,   2'b10, 1, 1, 1'b0, 32'h0000_0040, 1'b1};
        tbl[3] = '{0, 32'h0000_0123, 7,   2'b11, 0, 2, 1'b1, 32'h0000_0120, 1'b1};
        tbl[4] = '{0, 32'h0000_2000, 255, 2'b01, 2, 1, 1'b0, 32'h0000_2000, 1'b0};
        tbl[5] = '{1, 32'h0000_03F0, 1,   2'b00, 0, 3, 1'b1, 32'h0000_03F0, 1'b0};

        cpu_rst_n = 1'b0;
        wb_req = '0; wb_addr = '0; wb_len = '0;
        wb_data = '0; wb_data_valid = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
        repeat (3) @(negedge cpu_clk);
        chk("rst_awvalid", 64'(m_awvalid), 0);
        chk("rst_wvalid", 64'(m_wvalid), 0);
        chk("rst_bready", 64'(m_bready), 0);
        chk("rst_data_ready", 64'(wb_data_ready), 0);
        chk("rst_done_err", {wb_done, wb_err}, 0);
        chk("rst_ch", 64'(wb_data_ch), 0);
        chk("rst_state", 64'(dbg_state), 0);
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk);

        for (int i = 0; i < 6; i++) begin
            post_req(tbl[i].ch, tbl[i].addr, tbl[i].len);
            serve(tbl[i].ch, tbl[i].len, tbl[i].bresp, tbl[i].aw_delay, tbl[i].period,
                  tbl[i].toggle, tbl[i].exp_awaddr, tbl[i].exp_err, 0);
        end

        // Reset in the middle of a 16-beat burst; valids must drop at once.
        post_req(0, 32'h0000_0400, 15);
        serve(0, 15, 2'b00, 0, 1, 1'b0, 32'h0000_0400, 1'b0, 5);
        cpu_rst_n = 1'b0;
        #1;
        chk("mid_rst_awvalid", 64'(m_awvalid), 0);
        chk("mid_rst_wvalid", 64'(m_wvalid), 0);
        chk("mid_rst_data_ready", 64'(wb_data_ready), 0);
        chk("mid_rst_bready", 64'(m_bready), 0);
        chk("mid_rst_state", 64'(dbg_state), 0);
        wb_req = '0; wb_data_valid = 1'b0; m_wready = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        @(negedge cpu_clk);
        post_req(1, 32'h0000_0800, 3);
        serve(1, 3, 2'b00, 0, 1, 1'b0, 32'h0000_0800, 1'b0, 0);

        // Pointer is back at 0: simultaneous requests serve ch0 then ch1.
        post_req(0, 32'h0000_0100, 2);
        post_req(1, 32'h0000_0200, 1);
        serve(0, 2, 2'b00, 0, 1, 1'b0, 32'h0000_0100, 1'b0, 0);
        serve(1, 1, 2'b00, 0, 1, 1'b0, 32'h0000_0200, 1'b0, 0);
        // After a lone ch0 grant the pointer sits at 1, so ch1 wins the next tie.
        post_req(0, 32'h0000_0300, 0);
        serve(0, 0, 2'b00, 0, 1, 1'b0, 32'h0000_0300, 1'b0, 0);
        post_req(0, 32'h0000_0500, 1);
        post_req(1, 32'h0000_0600, 2);
        serve(1, 2, 2'b10, 1, 2, 1'b1, 32'h0000_0600, 1'b1, 0);
        serve(0, 1, 2'b00, 0, 1, 1'b0, 32'h0000_0500, 1'b0, 0);

`ifdef DMA_WB_BOUNDARY_CHECK_EN
        begin
            bit saw_aw;
            int n;
            saw_aw = 1'b0;
            n = 0;
            post_req(0, 32'h0000_0FC0, 31);
            @(negedge cpu_clk);
            while (wb_done == '0 && n < 20) begin
                if (m_awvalid) saw_aw = 1'b1;
                @(negedge cpu_clk);
                n++;
            end
            chk("bnd_no_aw", 64'(saw_aw), 0);
            chk("bnd_done", 64'(wb_done), 64'd1);
            chk("bnd_err", 64'(wb_err), 64'd1);
            wb_req[0] = 1'b0;
            @(negedge cpu_clk);
        end
`else
        post_req(0, 32'h0000_0FC0, 31);
        serve(0, 31, 2'b00, 0, 1, 1'b0, 32'h0000_0FC0, 1'b0, 0);
`endif
        post_req(1, 32'h0000_0F80, 31);
        serve(1, 31, 2'b00, 0, 1, 1'b0, 32'h0000_0F80, 1'b0, 0);

        repeat (2) @(negedge cpu_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
